// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one instruction-memory request at a time,
// registers the returned word for decode and handles branch-unit redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
  input  logic        DecReady,
  output logic        DecValid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [6:0]  OpCode,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic        Misaligned
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        dec_valid_q, dec_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] br_target;

  // Redirects are always word-aligned; low bits only feed the Misaligned flag.
  assign br_target = {BrTarget[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= 32'h0;
      instr_q      <= NOP_INSTR;
      pc_q         <= 32'h0;
      dec_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      dec_valid_q  <= dec_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    dec_valid_d  = dec_valid_q;
    misaligned_d = BrTaken & (BrTarget[1:0] != 2'b00);

    // A redirect always retargets the next fetch, whatever the state.
    if (BrTaken) begin
      fetch_pc_d = br_target;
    end

    unique case (state_q)
      FETCH: begin
        if (IMemGnt) begin
          if (BrTaken) begin
            state_d = DROP;
          end else begin
            state_d    = WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      WAIT: begin
        if (IMemRValid) begin
          if (BrTaken) begin
            state_d = FETCH;
          end else begin
            state_d     = HOLD;
            instr_d     = IMemRData;
            pc_d        = req_pc_q;
            dec_valid_d = 1'b1;
          end
        end else if (BrTaken) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (BrTaken) begin
          state_d     = FETCH;
          instr_d     = NOP_INSTR;
          dec_valid_d = 1'b0;
        end else if (DecReady) begin
          state_d     = FETCH;
          dec_valid_d = 1'b0;
        end
      end
      DROP: begin
        // Wrong-path response is swallowed here.
        if (IMemRValid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign IMemReq    = (state_q == FETCH) && !rst;
  assign IMemAddr   = fetch_pc_q;
  assign DecValid   = dec_valid_q;
  assign Instr      = instr_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  assign OpCode     = instr_q[6:0];
  assign Funct3     = instr_q[14:12];
  assign Funct7     = instr_q[31:25];
  assign Misaligned = misaligned_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit. Holds the PC and issues one instruction-memory request at a time over a variable-latency handshake.
- Registers the returned instruction and presents it to decode with valid/ready. OpCode/Funct3/Funct7 are sliced out for the control unit.
- Accepts taken-branch/jump redirects from the branch unit and discards any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction register contents after reset or flush (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- IMemReq  out  1  request valid to instruction memory
- IMemAddr  out  32  request address (FetchPC)
- IMemGnt  in  1  memory accepts request this cycle (only meaningful when IMemReq=1)
- IMemRValid  in  1  response valid, exactly one per granted request
- IMemRData  in  32  response instruction word
- BrTaken  in  1  redirect strobe from branch unit
- BrTarget  in  32  redirect address
- DecReady  in  1  decode consumes instruction this cycle
- DecValid  out  1  Instr/PC valid for decode
- Instr  out  32  registered instruction
- PC  out  32  address of Instr
- PCPlus4  out  32  PC+4
- OpCode  out  7  Instr[6:0]
- Funct3  out  3  Instr[14:12]
- Funct7  out  7  Instr[31:25]
- Misaligned  out  1  one-cycle pulse: redirect target had [1:0]!=0

Behaviour:
- Only one clock and one reset: synchronous, active-high `rst` sampled on the rising edge of `clk`.
- After any edge with rst=1:
  - state=FETCH, FetchPC=RESET_PC, ReqPC=0.
  - Instr=NOP_INSTR, PC=0, DecValid=0, Misaligned=0.
  - IMemReq is forced 0 while rst=1.
  - Instruction memory shares rst and drops any in-flight response, so none arrives after reset.
- Field outputs are combinational slices of the Instr register. PCPlus4=PC+32'd4, modulo 2^32.
- States: FETCH, WAIT, HOLD, DROP. At most one outstanding request.
- FETCH: IMemReq=1, IMemAddr=FetchPC.
  - IMemGnt & !BrTaken -> WAIT; ReqPC<=FetchPC; FetchPC<=FetchPC+4 (wraps 0xFFFF_FFFC -> 0).
  - IMemGnt & BrTaken -> DROP; FetchPC<=target.
  - !IMemGnt & BrTaken -> stay FETCH; FetchPC<=target.
- WAIT: IMemReq=0.
  - IMemRValid & !BrTaken -> HOLD; Instr<=IMemRData; PC<=ReqPC; DecValid<=1.
  - IMemRValid & BrTaken -> FETCH; response discarded; FetchPC<=target.
  - !IMemRValid & BrTaken -> DROP; FetchPC<=target.
- HOLD: DecValid=1, IMemReq=0. Instr/PC stable until consumed.
  - BrTaken (priority over DecReady) -> FETCH; Instr<=NOP_INSTR; DecValid<=0; FetchPC<=target.
  - DecReady -> FETCH; DecValid<=0.
- DROP: IMemReq=0.
  - IMemRValid -> FETCH; data discarded.
  - BrTaken here only updates FetchPC; a simultaneous IMemRValid is still discarded.
- Redirect target: target = {BrTarget[31:2],2'b00}. Misaligned<=1 for one cycle when BrTaken & BrTarget[1:0]!=0, in any state.
- IMemRValid outside WAIT/DROP is a protocol error; it is ignored.
- Throughput: best case 1 instruction per 3 cycles (grant, response, consume).

Test Plan:
- Reset release, memory grants immediately and responds 1 cycle later with 0x00500093 -> IMemAddr=0x0 on first cycle. DecValid=1 with Instr=0x00500093, OpCode=0x13, Funct3=0, PC=0, PCPlus4=4. Next IMemAddr=0x4.
- DecReady held low 5 cycles in HOLD -> Instr/PC unchanged, IMemReq=0 throughout. Release DecReady -> next fetch at PC+4.
- BrTaken with BrTarget=0x100 while in WAIT, response arriving 2 cycles later -> response dropped, DecValid never rises for it, next IMemAddr=0x100.
- BrTaken with BrTarget=0x200 in same cycle as IMemRValid in WAIT -> response discarded, FETCH at 0x200 next cycle, no DROP state entered.
- BrTaken in HOLD with DecReady=1 simultaneously -> DecValid drops, Instr=0x00000013, fetch resumes at target.
- BrTarget=0x0000_0106 -> Misaligned pulses 1 cycle, IMemAddr=0x104. Separately, FetchPC=0xFFFF_FFFC granted -> next IMemAddr=0x0, PCPlus4 of that instruction=0x0.
